single_min_reduce: RTL
======================

SINGLE_MIN_REDUCE -- requirements
Module: single_min_reduce

Interface
REQ-001 Parameter IDX_W, default 10, SHALL set index/count width (max vector length 2^IDX_W).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL mark in_data/in_last as valid.
REQ-005 in_ready  output  1  SHALL mark that the block accepts a beat this cycle.
REQ-006 in_data  input  32  SHALL carry an IEEE-754 single-precision element.
REQ-007 in_last  input  1  SHALL mark the final element of a vector.
REQ-008 out_valid  output  1  SHALL mark out_min/out_idx/out_ovf as valid.
REQ-009 out_ready  input  1  SHALL mark downstream acceptance of the result.
REQ-010 out_min  output  32  SHALL carry the minimum element of the vector.
REQ-011 out_idx  output  IDX_W  SHALL carry the zero-based position of out_min in the vector.
REQ-012 out_ovf  output  1  SHALL flag that the vector exceeded 2^IDX_W elements.

Function
REQ-013 A beat SHALL transfer only when in_valid and in_ready are both high; a result SHALL transfer only when out_valid and out_ready are both high.
REQ-014 FSM SHALL have states IDLE, ACCUM, HOLD; reset state IDLE.
REQ-015 IDLE: in_ready=1; an accepted beat SHALL load best=in_data, best_idx=0, count=1, ovf=0; go to ACCUM, or to HOLD if in_last.
REQ-016 ACCUM: in_ready=1; each accepted beat SHALL replace best/best_idx with in_data/count only when in_data is strictly less than best; count SHALL increment; go to HOLD on in_last.
REQ-017 HOLD: in_ready=0, out_valid=1; out_min/out_idx/out_ovf SHALL stay stable until transfer; on transfer go to IDLE.
REQ-018 out_valid SHALL rise the cycle after the in_last beat is accepted (latency 1); next vector's first beat SHALL be accepted no earlier than the cycle after the result transfers.
REQ-019 Ordering "a < b" SHALL be sign-magnitude: signs differ -> the negative one is less; both positive -> smaller a[30:0] is less; both negative -> larger a[30:0] is less; identical bits -> not less.
REQ-020 Consequences: -0.0 (0x80000000) SHALL be less than +0.0 (0x00000000); NaN and infinity SHALL be ordered by bit pattern under REQ-019, with no special casing.
REQ-021 Ties SHALL keep the earliest index.
REQ-022 count SHALL wrap modulo 2^IDX_W; on a wrap from all-ones to zero within a vector, ovf SHALL set and remain set until the result transfers; out_idx after wrap SHALL be the wrapped value.
REQ-023 A single-element vector (first beat has in_last) SHALL yield out_min=that element, out_idx=0.
REQ-024 in_valid low in ACCUM SHALL hold all state unchanged (bubbles allowed).

Reset
REQ-025 On rst high, asynchronously: state=IDLE, in_ready=0 while rst asserted then 1 from IDLE, out_valid=0, out_min=0, out_idx=0, out_ovf=0, count=0.
REQ-026 Reset asserted mid-vector or in HOLD SHALL discard the partial vector/pending result; no output beat SHALL appear for it.

Structure
REQ-027 Shared package single_pkg SHALL hold the FSM state typedef and the sign-magnitude less-than function.
REQ-028 Comparison SHALL be a combinational sub-module single_less (inputs a, b; output lt), reusable by the existing single-precision max logic.
REQ-029 Datapath SHALL be one comparator, one best register, one index register, one counter.

Verification
REQ-030 Vector {0x3F800000 (1.0), 0xC0000000 (-2.0), 0x3F000000 (0.5), last} -> out_min=0xC0000000, out_idx=1, out_ovf=0, out_valid one cycle after last.
REQ-031 Vector {0x00000000, 0x80000000, 0x80000000, last} -> out_min=0x80000000, out_idx=1 (tie keeps first).
REQ-032 Single beat 0x40400000 with in_last -> out_min=0x40400000, out_idx=0; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-033 IDX_W=2, 5-beat vector with min at position 4 -> out_ovf=1, out_idx=0.
REQ-034 Assert rst after 2 beats of a vector, release, send {0xBF800000, last} -> only result out_min=0xBF800000, out_idx=0.
REQ-035 Random in_valid bubbles and out_ready backpressure over 1000 vectors -> results match a software model using REQ-019 ordering.

Source files
------------

// File: rtl/single_pkg.sv
// Shared types and the sign-magnitude ordering used by the single-precision
// min/max reduction blocks.
package single_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Raw bit-pattern ordering: NaN and infinity get no special treatment.
  function automatic logic sm_less(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic r;
    if (a[FP_W-1] != b[FP_W-1]) begin
      r = a[FP_W-1];
    end else if (!a[FP_W-1]) begin
      r = (a[FP_W-2:0] < b[FP_W-2:0]);
    end else begin
      r = (a[FP_W-2:0] > b[FP_W-2:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/single_less.sv
// Combinational sign-magnitude "a < b" on single-precision bit patterns.
module single_less
  import single_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            lt
);

  assign lt = sm_less(a, b);

endmodule

// File: rtl/single_min_reduce.sv
// Streaming minimum reduction over single-precision vectors; reports the minimum,
// its earliest position, and an overflow flag when the position counter wraps.
module single_min_reduce
  import single_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_min,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf,
  output state_t           dbg_state
);

  // Handshake: a beat moves when in_valid && in_ready, a result when
  // out_valid && out_ready; both ready/valid outputs are registered and
  // never depend combinationally on the opposite side.
  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [FP_W-1:0]    r_best;
  logic [IDX_W-1:0]   r_best_idx;
  logic [IDX_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_lt;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_wrapped;

  single_less u_less (
    .a  (in_data),
    .b  (r_best),
    .lt (w_lt)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  // In ACCUM the counter only reads zero once the element position has wrapped.
  assign w_wrapped  = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_best     <= in_data;
            r_best_idx <= '0;
            r_count    <= IDX_W'(1);
            r_ovf      <= 1'b0;
            if (in_last) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end

        ST_ACCUM: begin
          if (w_in_xfer) begin
            if (w_lt) begin
              r_best     <= in_data;
              r_best_idx <= r_count;
            end
            r_count <= r_count + IDX_W'(1);
            if (w_wrapped) begin
              r_ovf <= 1'b1;
            end
            if (in_last) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (w_out_xfer) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_min   = r_best;
  assign out_idx   = r_best_idx;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule
